// File: rtl/pdp_rdma_ctrl_pkg.sv
// Shared encodings for the PDP RDMA ping-pong layer controller: group status
// values reported back to the register block and the layer sequencer states.
package pdp_rdma_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    function automatic status_e group_status(input logic en, input logic active);
        if (!en) return ST_IDLE;
        return active ? ST_RUN : ST_PEND;
    endfunction

endpackage

// File: rtl/pdp_rdma_group_flag.sv
// Per-group OP_ENABLE flag: a CPU write-1 sets it, a permitted write-0 or the
// layer completion clears it, and a set always beats a clear in the same cycle.
module pdp_rdma_group_flag (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_wr_i,
    input  logic clr_done_i,
    output logic en_o,
    output logic en_d_o
);

    logic en_q;
    logic en_d;

    // NOTE: the default assignment first means no path leaves en_d unassigned, so no latch.
    always_comb begin
        en_d = en_q;
        if (set_i) begin
            en_d = 1'b1;
        end else if (clr_wr_i || clr_done_i) begin
            en_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en_o   = en_q;
    assign en_d_o = en_d;

endmodule

// File: rtl/pdp_rdma_layer_ctrl.sv
// Ping-pong layer sequencer for the two PDP RDMA register groups.
// Optional layer cycle counter enabled by defining PDP_RDMA_LAYER_PERF_EN.
module pdp_rdma_layer_ctrl
    import pdp_rdma_ctrl_pkg::*;
#(
    parameter int PERF_W  = 32,
    parameter int GAP_CYC = 1
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              producer,
    input  logic              op_en_wr,
    input  logic              op_en_wr_data,
    input  logic              dp_op_done,
    output logic              consumer,
    output logic [1:0]        status_0,
    output logic [1:0]        status_1,
    output logic              dp_op_en,
    output logic              dp_op_load,
    output logic [1:0]        done_intr
`ifdef PDP_RDMA_LAYER_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_layer_cycles
`endif
);

    if (GAP_CYC < 1 || GAP_CYC > 3 || PERF_W < 1) begin : g_bad_param
        $error("pdp_rdma_layer_ctrl: GAP_CYC must be 1..3 and PERF_W at least 1");
    end

    localparam logic [1:0] GAP_LOAD = 2'(GAP_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] gap_q, gap_d;
    logic       consumer_q, consumer_d;
    logic       load_q, load_d;
    logic [1:0] done_q, done_d;
    logic [1:0] en_q, en_d;
    status_e    status_q [2];
    status_e    status_d [2];
    logic       done_run;

    assign done_run = dp_op_done && (state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        consumer_d = consumer_q;
        load_d     = 1'b0;
        done_d     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (en_q[consumer_q]) begin
                    state_d = S_RUN;
                    load_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (dp_op_done) begin
                    state_d            = S_GAP;
                    gap_d              = GAP_LOAD;
                    consumer_d         = ~consumer_q;
                    done_d[consumer_q] = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-0 to the group the datapath owns is only honoured while idle.
    for (genvar g = 0; g < 2; g++) begin : g_grp
        logic wr_hit;
        assign wr_hit = op_en_wr && (producer == 1'(g));

        pdp_rdma_group_flag u_flag (
            .clk_i      (nvdla_core_clk),
            .rst_i      (nvdla_core_rst),
            .set_i      (wr_hit && op_en_wr_data),
            .clr_wr_i   (wr_hit && !op_en_wr_data &&
                         ((consumer_q != 1'(g)) || (state_q == S_IDLE))),
            .clr_done_i (done_run && (consumer_q == 1'(g))),
            .en_o       (en_q[g]),
            .en_d_o     (en_d[g])
        );

        assign status_d[g] = group_status(en_d[g],
                                          (consumer_d == 1'(g)) && (state_d == S_RUN));
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q     <= S_IDLE;
            gap_q       <= 2'd0;
            consumer_q  <= 1'b0;
            load_q      <= 1'b0;
            done_q      <= 2'b00;
            status_q[0] <= ST_IDLE;
            status_q[1] <= ST_IDLE;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            consumer_q  <= consumer_d;
            load_q      <= load_d;
            done_q      <= done_d;
            status_q[0] <= status_d[0];
            status_q[1] <= status_d[1];
        end
    end

    assign consumer   = consumer_q;
    assign status_0   = status_q[0];
    assign status_1   = status_q[1];
    assign dp_op_en   = (state_q == S_RUN);
    assign dp_op_load = load_q;
    assign done_intr  = done_q;

`ifdef PDP_RDMA_LAYER_PERF_EN
    logic [PERF_W-1:0] perf_cnt_q, perf_cnt_d;
    logic [PERF_W-1:0] perf_out_q, perf_out_d;

    // The load cycle is itself a RUN cycle, so the count restarts at one.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_out_d = perf_out_q;
        if (state_q == S_RUN) begin
            if (load_q) begin
                perf_cnt_d = PERF_W'(1);
            end else if (perf_cnt_q != '1) begin
                perf_cnt_d = perf_cnt_q + PERF_W'(1);
            end
            if (dp_op_done) begin
                perf_out_d = perf_cnt_d;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            perf_cnt_q <= '0;
            perf_out_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_out_q <= perf_out_d;
        end
    end

    assign perf_layer_cycles = perf_out_q;
`endif

endmodule
